// File: rtl/ethernet_rx_drain.sv
// ethernet_rx_drain: drains frames from the ethernet_controller RX buffer over
// its register port and replays each frame as a ready/valid word stream.
module ethernet_rx_drain #(
   parameter int                      data_width_p   = 32,
   parameter int                      addr_width_p   = 14,
   parameter int                      eth_mtu_p      = 2048,
   parameter logic [addr_width_p-1:0] rx_buf_base_p  = 14'h0000,
   parameter logic [addr_width_p-1:0] rx_size_addr_p = 14'h1004,
   parameter logic [addr_width_p-1:0] rx_ack_addr_p  = 14'h1008
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      rx_pending_i,
   output logic [addr_width_p-1:0]   addr_o,
   output logic                      read_en_o,
   output logic                      write_en_o,
   output logic [$clog2((($clog2(data_width_p/8) < 1) ? 1 : $clog2(data_width_p/8)) + 1)-1:0] op_size_o,
   output logic [data_width_p-1:0]   write_data_o,
   input  logic [data_width_p-1:0]   read_data_i,
   output logic [data_width_p-1:0]   m_tdata_o,
   output logic [data_width_p/8-1:0] m_tkeep_o,
   output logic                      m_tvalid_o,
   output logic                      m_tlast_o,
   input  logic                      m_tready_i,
   output logic [15:0]               frame_count_o,
   output logic                      size_error_o
);

   localparam int bytes_lp  = data_width_p / 8;
   localparam int size_w_lp = $clog2(eth_mtu_p + 1);
   localparam int op_w_lp   = $clog2((($clog2(bytes_lp) < 1) ? 1 : $clog2(bytes_lp)) + 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] RD_SIZE   = 3'd1;
   localparam logic [2:0] WAIT_SIZE = 3'd2;
   localparam logic [2:0] RD_DATA   = 3'd3;
   localparam logic [2:0] WAIT_DATA = 3'd4;
   localparam logic [2:0] STREAM    = 3'd5;
   localparam logic [2:0] ACK       = 3'd6;
   localparam logic [2:0] HOLD      = 3'd7;

   localparam logic [size_w_lp-1:0] bytes_c = size_w_lp'(bytes_lp);
   localparam logic [size_w_lp-1:0] mtu_c   = size_w_lp'(eth_mtu_p);

   logic [2:0]                state_q, state_d;
   logic [size_w_lp-1:0]      remaining_q, remaining_d;
   logic [addr_width_p-1:0]   offset_q, offset_d;
   logic [data_width_p-1:0]   tdata_q, tdata_d;
   logic [bytes_lp-1:0]       tkeep_q, tkeep_d;
   logic                      tlast_q, tlast_d;
   logic [15:0]               count_q, count_d;
   logic                      dropped_q, dropped_d;
   logic                      hold_q, hold_d;

   logic [size_w_lp-1:0]      size_field;
   logic                      size_bad;
   logic [bytes_lp-1:0]       keep_c;
   logic [size_w_lp-1:0]      step_c;

   // Bits above the size field are ignored; zero or oversize frames are dropped.
   assign size_field = read_data_i[size_w_lp-1:0];
   assign size_bad   = (size_field == '0) || (size_field > mtu_c);
   assign step_c     = (remaining_q < bytes_c) ? remaining_q : bytes_c;

   // Byte lane i is valid while more than i bytes of the frame remain.
   for (genvar gi = 0; gi < bytes_lp; gi++) begin : g_keep
      assign keep_c[gi] = (remaining_q > size_w_lp'(gi));
   end

   // Next-state and datapath updates for the drain sequence.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      offset_d    = offset_q;
      tdata_d     = tdata_q;
      tkeep_d     = tkeep_q;
      tlast_d     = tlast_q;
      count_d     = count_q;
      dropped_d   = dropped_q;
      hold_d      = hold_q;
      case (state_q)
         IDLE: begin
            if (rx_pending_i) state_d = RD_SIZE;
         end
         RD_SIZE: state_d = WAIT_SIZE;
         WAIT_SIZE: begin
            remaining_d = size_field;
            offset_d    = '0;
            dropped_d   = size_bad;
            state_d     = size_bad ? ACK : RD_DATA;
         end
         RD_DATA: state_d = WAIT_DATA;
         WAIT_DATA: begin
            tdata_d = read_data_i;
            tkeep_d = keep_c;
            tlast_d = (remaining_q <= bytes_c);
            state_d = STREAM;
         end
         STREAM: begin
            if (m_tready_i) begin
               offset_d    = offset_q + addr_width_p'(bytes_lp);
               remaining_d = remaining_q - step_c;
               state_d     = tlast_q ? ACK : RD_DATA;
            end
         end
         ACK: begin
            if (!dropped_q) count_d = count_q + 16'd1;
            hold_d  = 1'b0;
            state_d = HOLD;
         end
         HOLD: begin
            // Two quiet cycles give the controller time to lower its pending flag.
            if (hold_q) begin
               hold_d  = 1'b0;
               state_d = IDLE;
            end else begin
               hold_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; an asynchronous reset abandons any frame in flight without ACK.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         offset_q    <= '0;
         tdata_q     <= '0;
         tkeep_q     <= '0;
         tlast_q     <= 1'b0;
         count_q     <= '0;
         dropped_q   <= 1'b0;
         hold_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         offset_q    <= offset_d;
         tdata_q     <= tdata_d;
         tkeep_q     <= tkeep_d;
         tlast_q     <= tlast_d;
         count_q     <= count_d;
         dropped_q   <= dropped_d;
         hold_q      <= hold_d;
      end
   end

   // Bus strobes, address and write data decoded purely from state.
   always_comb begin
      addr_o       = '0;
      read_en_o    = 1'b0;
      write_en_o   = 1'b0;
      write_data_o = '0;
      case (state_q)
         RD_SIZE: begin
            read_en_o = 1'b1;
            addr_o    = rx_size_addr_p;
         end
         RD_DATA: begin
            read_en_o = 1'b1;
            addr_o    = rx_buf_base_p + offset_q;
         end
         ACK: begin
            write_en_o   = 1'b1;
            addr_o       = rx_ack_addr_p;
            write_data_o = data_width_p'(1);
         end
         default: ;
      endcase
   end

   assign op_size_o     = op_w_lp'($clog2(bytes_lp));
   assign m_tdata_o     = tdata_q;
   assign m_tkeep_o     = tkeep_q;
   assign m_tlast_o     = tlast_q;
   assign m_tvalid_o    = (state_q == STREAM);
   assign frame_count_o = count_q;
   assign size_error_o  = (state_q == WAIT_SIZE) && size_bad;

endmodule

// File: tb/tb_ethernet_rx_drain.sv
// Bench for ethernet_rx_drain: a controller model serves frames from a queue,
// a monitor logs bus and stream activity, and directed steps compare the logs
// against frame contents derived from each frame's size and seed.
module tb_ethernet_rx_drain;

   localparam logic [13:0] SIZE_A = 14'h1004;
   localparam logic [13:0] ACK_A  = 14'h1008;

   logic        clk = 1'b0;
   logic        reset_n_i = 1'b0;
   logic        rx_pending_i;
   logic [13:0] addr_o;
   logic        read_en_o, write_en_o;
   logic [1:0]  op_size_o;
   logic [31:0] write_data_o;
   logic [31:0] read_data_i = '0;
   logic [31:0] m_tdata_o;
   logic [3:0]  m_tkeep_o;
   logic        m_tvalid_o, m_tlast_o;
   logic        m_tready_i = 1'b1;
   logic [15:0] frame_count_o;
   logic        size_error_o;

   ethernet_rx_drain dut (
      .clk_i(clk), .reset_n_i(reset_n_i), .rx_pending_i(rx_pending_i),
      .addr_o(addr_o), .read_en_o(read_en_o), .write_en_o(write_en_o),
      .op_size_o(op_size_o), .write_data_o(write_data_o), .read_data_i(read_data_i),
      .m_tdata_o(m_tdata_o), .m_tkeep_o(m_tkeep_o), .m_tvalid_o(m_tvalid_o),
      .m_tlast_o(m_tlast_o), .m_tready_i(m_tready_i),
      .frame_count_o(frame_count_o), .size_error_o(size_error_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Frame queue: pushed by the stimulus, popped by the controller model on ACK.
   int         fr_size [0:15];
   logic [7:0] fr_seed [0:15];
   int         pushed = 0;
   int         popped = 0;
   assign rx_pending_i = (pushed != popped);

   function automatic logic [7:0] fbyte(int id, int i);
      return 8'(int'(fr_seed[id]) + i * 167 + ((i * i) >> 2));
   endfunction

   // Controller model: synchronous register reads, frame release on ACK write.
   logic [31:0] rd_word;
   always @(posedge clk) begin
      if (read_en_o) begin
         if (addr_o == SIZE_A) begin
            rd_word = {20'($urandom), 12'(fr_size[popped])};
         end else begin
            for (int k = 0; k < 4; k++) rd_word[8*k +: 8] = fbyte(popped, int'(addr_o) + k);
         end
         read_data_i <= rd_word;
      end
      if (write_en_o && addr_o == ACK_A && pushed != popped) popped <= popped + 1;
   end

   // Downstream ready: always 1 or a 50% coin toss, changed just after each edge.
   bit rand_ready = 1'b0;
   always @(posedge clk) begin
      #1;
      m_tready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor logs, sampled mid-cycle.
   int          size_rd_cyc[$], data_rd_cyc[$], ack_cyc[$], err_cyc[$], hs_cyc[$];
   logic [13:0] data_addrs[$];
   logic [36:0] beats[$];
   int          ack_cnt = 0;
   int          excl_viol = 0;
   int          ack_bad = 0;
   int          stall_viol = 0;
   bit          prev_stall = 1'b0;
   logic [36:0] prev_beat;
   always @(negedge clk) begin
      if (reset_n_i) begin
         if (read_en_o && write_en_o) excl_viol++;
         if (read_en_o) begin
            if (addr_o == SIZE_A) size_rd_cyc.push_back(cyc);
            else begin
               data_rd_cyc.push_back(cyc);
               data_addrs.push_back(addr_o);
            end
         end
         if (write_en_o) begin
            ack_cyc.push_back(cyc);
            ack_cnt++;
            if (addr_o != ACK_A || write_data_o != 32'd1) ack_bad++;
         end
         if (size_error_o) err_cyc.push_back(cyc);
         if (prev_stall && (!m_tvalid_o || {m_tlast_o, m_tkeep_o, m_tdata_o} != prev_beat))
            stall_viol++;
         if (m_tvalid_o && m_tready_i) begin
            beats.push_back({m_tlast_o, m_tkeep_o, m_tdata_o});
            hs_cyc.push_back(cyc);
         end
         prev_stall = m_tvalid_o && !m_tready_i;
         prev_beat  = {m_tlast_o, m_tkeep_o, m_tdata_o};
      end else begin
         prev_stall = 1'b0;
      end
   end

   logic [36:0] exp_beats[$];

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Queue a frame and derive its expected beats from size and contents.
   task automatic push_frame(int size);
      int nb, n;
      logic [31:0] d;
      fr_size[pushed] = size;
      fr_seed[pushed] = 8'($urandom);
      if (size >= 1 && size <= 2048) begin
         nb = (size + 3) / 4;
         for (int k = 0; k < nb; k++) begin
            for (int j = 0; j < 4; j++) d[8*j +: 8] = fbyte(pushed, 4*k + j);
            n = size - 4*k;
            if (n > 4) n = 4;
            exp_beats.push_back({(k == nb - 1), 4'((1 << n) - 1), d});
         end
      end
      pushed++;
   endtask

   task automatic wait_acks(string tag, int target, int budget);
      int n = 0;
      while (ack_cnt < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      check(tag, 64'(ack_cnt), 64'(target));
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_beats(string tag, int bmark, int emark, int n);
      check({tag, "_nbeats"}, 64'(beats.size() - bmark), 64'(n));
      for (int i = 0; i < n; i++)
         if (bmark + i < beats.size())
            check($sformatf("%s_beat%0d", tag, i), 64'(beats[bmark+i]), 64'(exp_beats[emark+i]));
   endtask

   task automatic check_outputs_zero(string tag);
      check({tag, "_bus"}, {addr_o, read_en_o, write_en_o, write_data_o}, 64'd0);
      check({tag, "_strm"}, {m_tdata_o, m_tkeep_o, m_tvalid_o, m_tlast_o}, 64'd0);
      check({tag, "_misc"}, {frame_count_o, size_error_o}, 64'd0);
   endtask

   int m_sz, m_drd, m_ack, m_err, m_hs, m_beat, m_exp, fc0;

   task automatic take_marks();
      m_sz = size_rd_cyc.size(); m_drd = data_rd_cyc.size(); m_ack = ack_cyc.size();
      m_err = err_cyc.size(); m_hs = hs_cyc.size(); m_beat = beats.size(); m_exp = exp_beats.size();
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      check("op_size", 64'(op_size_o), 64'd2);
      reset_n_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 64-byte frame, ready held high: contents, addresses and latency
      take_marks();
      push_frame(64);
      wait_acks("f64_ack", ack_cnt + 1, 400);
      check_beats("f64", m_beat, m_exp, 16);
      check("f64_nrd", 64'(data_addrs.size() - m_drd), 64'd16);
      for (int i = 0; i < 16; i++)
         if (m_drd + i < data_addrs.size())
            check($sformatf("f64_addr%0d", i), 64'(data_addrs[m_drd+i]), 64'(4*i));
      if (data_rd_cyc.size() > m_drd && size_rd_cyc.size() > m_sz && hs_cyc.size() >= m_hs + 16 && ack_cyc.size() > m_ack) begin
         check("lat_rd_data", 64'(data_rd_cyc[m_drd] - size_rd_cyc[m_sz]), 64'd2);
         check("lat_valid", 64'(hs_cyc[m_hs] - size_rd_cyc[m_sz]), 64'd4);
         check("thru_span", 64'(hs_cyc[m_hs+15] - hs_cyc[m_hs]), 64'd45);
         check("ack_after_last", 64'(ack_cyc[m_ack] - hs_cyc[m_hs+15]), 64'd1);
      end
      check("f64_count", 64'(frame_count_o), 64'd1);
      check("f64_noerr", 64'(err_cyc.size() - m_err), 64'd0);

      // 61-byte frame: short final word
      take_marks();
      push_frame(61);
      wait_acks("f61_ack", ack_cnt + 1, 400);
      check_beats("f61", m_beat, m_exp, 16);
      if (beats.size() == m_beat + 16)
         check("f61_lastkeep", 64'(beats[m_beat+15][36:32]), 64'b1_0001);
      check("f61_count", 64'(frame_count_o), 64'd2);

      // 128-byte frame with random backpressure
      take_marks();
      rand_ready = 1'b1;
      push_frame(128);
      wait_acks("f128_ack", ack_cnt + 1, 1500);
      rand_ready = 1'b0;
      check_beats("f128", m_beat, m_exp, 32);
      check("f128_one_ack", 64'(ack_cyc.size() - m_ack), 64'd1);
      check("f128_stable", 64'(stall_viol), 64'd0);
      check("f128_count", 64'(frame_count_o), 64'd3);

      // Illegal sizes 0 and 2049: dropped, acknowledged, not counted
      for (int t = 0; t < 2; t++) begin
         take_marks();
         push_frame(t == 0 ? 0 : 2049);
         wait_acks($sformatf("bad%0d_ack", t), ack_cnt + 1, 100);
         check($sformatf("bad%0d_err", t), 64'(err_cyc.size() - m_err), 64'd1);
         check($sformatf("bad%0d_nrd", t), 64'(data_rd_cyc.size() - m_drd), 64'd0);
         check($sformatf("bad%0d_nbeat", t), 64'(beats.size() - m_beat), 64'd0);
         if (err_cyc.size() > m_err && size_rd_cyc.size() > m_sz && ack_cyc.size() > m_ack) begin
            check($sformatf("bad%0d_errcyc", t), 64'(err_cyc[m_err] - size_rd_cyc[m_sz]), 64'd1);
            check($sformatf("bad%0d_ackcyc", t), 64'(ack_cyc[m_ack] - size_rd_cyc[m_sz]), 64'd2);
         end
         check($sformatf("bad%0d_count", t), 64'(frame_count_o), 64'd3);
      end

      // Largest legal frame
      take_marks();
      push_frame(2048);
      wait_acks("f2048_ack", ack_cnt + 1, 2000);
      check_beats("f2048", m_beat, m_exp, 512);
      check("f2048_count", 64'(frame_count_o), 64'd4);

      // Reset during beat 5 of a 64-byte frame, then full re-drain
      take_marks();
      push_frame(64);
      begin
         int n = 0;
         while (beats.size() - m_beat < 5 && n < 200) begin
            @(negedge clk);
            n++;
         end
         check("rst_reach_beat5", 64'(beats.size() - m_beat), 64'd5);
      end
      #2;
      reset_n_i = 1'b0;
      #1;
      check_outputs_zero("rst_mid");
      repeat (2) @(posedge clk);
      #1;
      reset_n_i = 1'b1;
      m_beat = beats.size();
      m_drd  = data_rd_cyc.size();
      wait_acks("rst_ack", ack_cnt + 1, 400);
      check_beats("rst", m_beat, m_exp, 16);
      if (data_addrs.size() > m_drd)
         check("rst_addr0", 64'(data_addrs[m_drd]), 64'd0);
      check("rst_count", 64'(frame_count_o), 64'd1);

      // Two queued frames: pending stays high across the first ACK
      take_marks();
      fc0 = int'(frame_count_o);
      push_frame(20);
      push_frame(37);
      wait_acks("two_ack", ack_cnt + 2, 800);
      check_beats("two", m_beat, m_exp, 15);
      if (size_rd_cyc.size() >= m_sz + 2 && ack_cyc.size() > m_ack)
         check("two_gap", 64'(size_rd_cyc[m_sz+1] - ack_cyc[m_ack]), 64'd4);
      check("two_count", 64'(frame_count_o), 64'(fc0 + 1 + 1));

      // Whole-run bus integrity
      check("rw_exclusive", 64'(excl_viol), 64'd0);
      check("ack_writes", 64'(ack_bad), 64'd0);
      check("stall_stable", 64'(stall_viol), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ethernet_rx_drain.md
# ethernet_rx_drain

Register-bus initiator that empties the receive buffer of `ethernet_controller` and re-emits each frame as an AXI-Stream-style word stream. It sits between the controller's register port and a downstream consumer, such as a packet filter or a loopback path into the TX side. It replaces software polling for hardware-only datapaths. It waits for the controller's RX interrupt, reads the frame size, reads the frame word by word, streams it out, and acknowledges the frame.

## Interface
Parameters:
- `data_width_p`, 32: register bus and stream word width in bits; power of two, ≥16.
- `addr_width_p`, 14: register address width.
- `eth_mtu_p`, 2048: maximum legal frame size in bytes.
- `rx_buf_base_p`, 14'h0000: byte address of RX buffer byte 0.
- `rx_size_addr_p`, 14'h1004: address of the RX frame-size register; size is in bits [$clog2(eth_mtu_p+1)-1:0].
- `rx_ack_addr_p`, 14'h1008: address of the RX acknowledge register. Any write releases the frame.

Ports:
- `clk_i`  in  1: single clock, same domain as controller `clk_i`.
- `reset_n_i`  in  1: asynchronous, active-low reset.
- `rx_pending_i`  in  1: controller RX interrupt (frame available).
- `addr_o`  out  addr_width_p: register byte address.
- `read_en_o`  out  1: read strobe. Data returns on `read_data_i` the following cycle (sync read).
- `write_en_o`  out  1: write strobe.
- `op_size_o`  out  BSG_WIDTH(BSG_SAFE_CLOG2(data_width_p/8)): constant $clog2(data_width_p/8), i.e. full-word access.
- `write_data_o`  out  data_width_p: write data. It is 1 during ACK and 0 otherwise.
- `read_data_i`  in  data_width_p: read data.
- `m_tdata_o`  out  data_width_p: stream data, byte 0 in bits [7:0].
- `m_tkeep_o`  out  data_width_p/8: byte-valid mask.
- `m_tvalid_o`  out  1: stream valid.
- `m_tlast_o`  out  1: last word of the frame.
- `m_tready_i`  in  1: stream ready.
- `frame_count_o`  out  16: frames streamed successfully; wraps modulo 2^16.
- `size_error_o`  out  1: one-cycle pulse when a frame is dropped for an illegal size.

## Operation
- The FSM states are IDLE, RD_SIZE, WAIT_SIZE, RD_DATA, WAIT_DATA, STREAM, ACK and HOLD.
- **IDLE:** if `rx_pending_i`=1, go to RD_SIZE.
- **RD_SIZE:** drive `read_en_o`=1 and `addr_o`=`rx_size_addr_p`. Go to WAIT_SIZE.
- **WAIT_SIZE:** capture the size into `remaining` (a 12-bit byte counter) and clear `offset`.
  - If size is 0 or size > `eth_mtu_p`: pulse `size_error_o` and go to ACK. The frame is dropped and no stream beats are produced.
  - Otherwise go to RD_DATA.
- **RD_DATA:** drive `read_en_o`=1 and `addr_o`=`rx_buf_base_p`+`offset`. Go to WAIT_DATA.
- **WAIT_DATA:** register `read_data_i` into `m_tdata_o`.
  - `m_tkeep_o` is all-ones if `remaining` ≥ B (B = data_width_p/8). Otherwise it is (1<<`remaining`)-1.
  - `m_tlast_o` is (`remaining` ≤ B).
  - Go to STREAM.
- **STREAM:** `m_tvalid_o`=1. Data, keep and last stay stable until `m_tready_i`=1. On the handshake:
  - `offset` += B.
  - `remaining` -= min(`remaining`, B).
  - If this was the last word, go to ACK; otherwise go to RD_DATA.
- **ACK:** drive `write_en_o`=1, `addr_o`=`rx_ack_addr_p`, `write_data_o`=1.
  - If the frame was streamed, increment `frame_count_o`.
  - Go to HOLD.
- **HOLD:** stay 2 cycles, ignoring `rx_pending_i` so the controller's pending flag can drop. Then go to IDLE.
- `read_en_o` and `write_en_o` are never both 1. Bus strobes are decoded from state (Moore outputs).
- Outside RD_SIZE, RD_DATA and ACK: `addr_o`=0, `read_en_o`=0, `write_en_o`=0.
- `offset` arithmetic stays in `addr_width_p` bits. No wrap is possible because size ≤ `eth_mtu_p`.

## Timing
- **Reset values:** state is IDLE. `addr_o`, `read_en_o`, `write_en_o`, `write_data_o`, `m_tdata_o`, `m_tkeep_o`, `m_tvalid_o`, `m_tlast_o`, `frame_count_o` and `size_error_o` are all 0. `op_size_o` is its constant value.
- **Reset mid-frame:** takes effect immediately (asynchronous) and no ACK is issued. The frame is still pending in the controller and is re-drained from the start after reset is released.
- **Latency:** with `rx_pending_i` sampled high in IDLE at cycle 0:
  - RD_SIZE is cycle 1 and RD_DATA is cycle 3.
  - First `m_tvalid_o`=1 is cycle 5.
- **Throughput:** each word costs 3 cycles with `m_tready_i` held at 1. The ACK write occurs the cycle after the last handshake.
- **Dropped frame:** `size_error_o` is high in the WAIT_SIZE cycle (cycle 2) and ACK follows in cycle 3.
- **Back-to-back frames:** the earliest next RD_SIZE is 4 cycles after ACK (ACK, HOLD, HOLD, IDLE, then RD_SIZE).
- **Backpressure:** `m_tvalid_o` is never withdrawn without a handshake.

## Test plan
- **64-byte frame, ready tied 1:**
  - 16 beats, keep 4'hF on every beat, `m_tlast_o` on beat 16 only.
  - Data matches buffer bytes 0..63 and read addresses are 0x000..0x03C.
  - One ACK write to 0x1008, then `frame_count_o`=1.
- **61-byte frame:** 16 beats; the last beat has keep 4'b0001 and `m_tlast_o`=1.
- **Random `m_tready_i` (50%) on a 128-byte frame:**
  - `m_tdata_o`, `m_tkeep_o` and `m_tlast_o` are stable while valid && !ready.
  - No beat is lost or duplicated.
  - Exactly one ACK write.
- **Illegal sizes:** size 0, then size 2049:
  - `size_error_o` pulses once for each.
  - No beats are produced and no RD_DATA read is issued.
  - Each is ACKed and `frame_count_o` is unchanged.
- **Reset mid-frame:** assert `reset_n_i` low during beat 5 of a 64-byte frame.
  - All outputs go to 0 at once.
  - After release with `rx_pending_i` still 1, the full 16-beat frame is re-streamed from byte 0.
- **Two queued frames:** `rx_pending_i` stays 1 across the first ACK.
  - The second RD_SIZE is issued exactly 4 cycles after the first ACK.
  - `frame_count_o` ends at 2.
